// File: rtl/pc_gen.sv
// pc_gen: next-PC generator in front of a 1-cycle-latency instruction BRAM.
// Tracks the PC of the word currently on `inst`, predicts statically on that
// word (JAL taken, backward branch taken, return via RAS) and presents it to
// decode with zero-bubble redirection. A backend redirect overrides everything.
//
// Handshake toward decode: id_valid qualifies id_pc/id_pred_*/inst. When
// id_valid & stall, the word is held and all id_* outputs stay stable. The word
// is consumed on a cycle with id_valid & ~stall, and only then does the RAS move.
module pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4,
    parameter bit          BTFN_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] inst,
    output logic [31:0] pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target,
    output logic        dbg_run
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

    typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} st_e;

    st_e           r_st;
    st_e           w_st_next;
    logic [31:0]   r_fpc;
    logic          r_vld;
    logic [31:0]   r_ras_mem [RAS_DEPTH];
    logic [PW-1:0] r_ras_top;
    logic [PW:0]   r_ras_cnt;

    logic [6:0]    w_op;
    logic [4:0]    w_rd;
    logic [4:0]    w_rs1;
    logic          w_is_jal;
    logic          w_is_jalr;
    logic          w_is_br;
    logic          w_rd_link;
    logic          w_rs1_link;
    logic [31:0]   w_j_imm;
    logic [31:0]   w_b_imm;
    logic [31:0]   w_fpc_plus4;
    logic          w_ret;
    logic          w_push;
    logic          w_swap;
    logic          w_consume;
    logic          w_hold;
    logic          w_pred_taken;
    logic [31:0]   w_pred_target;
    logic          w_unused;

    // Decode of the returned word; only meaningful while r_vld is set
    assign w_op        = inst[6:0];
    assign w_rd        = inst[11:7];
    assign w_rs1       = inst[19:15];
    assign w_is_jal    = r_vld & (w_op == 7'b1101111);
    assign w_is_jalr   = r_vld & (w_op == 7'b1100111);
    assign w_is_br     = r_vld & (w_op == 7'b1100011);
    assign w_rd_link   = (w_rd == 5'd1) | (w_rd == 5'd5);
    assign w_rs1_link  = (w_rs1 == 5'd1) | (w_rs1 == 5'd5);
    assign w_j_imm     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_b_imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_fpc_plus4 = r_fpc + 32'd4;

    // A return pops only when the stack holds something; a link-to-link JALR
    // with different registers replaces the top entry instead of push+pop.
    assign w_ret   = w_is_jalr & (w_rd == 5'd0) & w_rs1_link & (r_ras_cnt != '0);
    assign w_push  = (w_is_jal | w_is_jalr) & w_rd_link;
    assign w_swap  = w_is_jalr & w_rd_link & w_rs1_link & (w_rd != w_rs1);

    // redirect targets are word aligned; the low bits are deliberately dropped
    assign w_unused = ^redirect_pc[1:0];

    // Static prediction on the current word
    always_comb begin
        w_pred_taken  = 1'b0;
        w_pred_target = w_fpc_plus4;
        if (w_is_jal) begin
            w_pred_taken  = 1'b1;
            w_pred_target = r_fpc + w_j_imm;
        end else if (w_is_br && BTFN_EN && inst[31]) begin
            w_pred_taken  = 1'b1;
            w_pred_target = r_fpc + w_b_imm;
        end else if (w_ret) begin
            w_pred_taken  = 1'b1;
            w_pred_target = r_ras_mem[r_ras_top];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_st <= ST_BOOT;
        else        r_st <= w_st_next;
    end

    // FSM next state: any redirect or the boot fetch moves to RUN
    always_comb begin
        w_st_next = r_st;
        if (redirect_valid || r_st == ST_BOOT) w_st_next = ST_RUN;
    end

    // FSM outputs: fetch address mux and decode qualification
    always_comb begin
        w_hold = 1'b0;
        pc     = w_pred_target;
        if (redirect_valid) begin
            pc = {redirect_pc[31:2], 2'b00};
        end else if (r_st == ST_BOOT) begin
            pc = RESET_PC;
        end else if (stall && r_vld) begin
            pc     = r_fpc;
            w_hold = 1'b1;
        end
        id_valid = r_vld & ~redirect_valid & (r_st == ST_RUN);
    end

    assign w_consume      = id_valid & ~stall;
    assign id_pc          = r_fpc;
    assign id_pred_taken  = w_pred_taken;
    assign id_pred_target = w_pred_target;
    assign dbg_run        = (r_st == ST_RUN);

    // Remember which address the next BRAM word belongs to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc <= RESET_PC;
            r_vld <= 1'b0;
        end else if (!w_hold) begin
            r_fpc <= pc;
            r_vld <= 1'b1;
        end
    end

    // RAS pointer and occupancy; a full push wraps and drops the oldest entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ras_top <= '0;
            r_ras_cnt <= '0;
        end else if (w_consume) begin
            if (w_swap) begin
                r_ras_top <= r_ras_top;
            end else if (w_push) begin
                r_ras_top <= r_ras_top + 1'b1;
                if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + 1'b1;
            end else if (w_ret) begin
                r_ras_top <= r_ras_top - 1'b1;
                r_ras_cnt <= r_ras_cnt - 1'b1;
            end
        end
    end

    // RAS storage: swap rewrites the top, push writes the slot above it
    always_ff @(posedge clk) begin
        if (rst_n && w_consume) begin
            if (w_swap)      r_ras_mem[r_ras_top]        <= w_fpc_plus4;
            else if (w_push) r_ras_mem[r_ras_top + 1'b1] <= w_fpc_plus4;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus a randomized run, with a queue-based
// reference model checking every cycle of the main instance. A second
// instance with backward-taken prediction disabled covers the BTFN_EN=0 case.
module tb_pc_gen;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        dbg_run;

    logic [31:0] inst_nb;
    logic [31:0] pc_nb;
    logic        valid_nb;
    logic [31:0] id_pc_nb;
    logic        taken_nb;
    logic [31:0] tgt_nb;
    logic        dbg_nb;

    int n_checks;
    int n_fail;

    pc_gen #(.RESET_PC(32'h0), .RAS_DEPTH(DEPTH), .BTFN_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst(inst), .pc(pc), .id_valid(id_valid),
        .id_pc(id_pc), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .dbg_run(dbg_run)
    );

    pc_gen #(.RESET_PC(32'h0), .RAS_DEPTH(DEPTH), .BTFN_EN(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .inst(inst_nb), .pc(pc_nb), .id_valid(valid_nb),
        .id_pc(id_pc_nb), .id_pred_taken(taken_nb), .id_pred_target(tgt_nb),
        .dbg_run(dbg_nb)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input int imm);
        logic [20:0] im;
        im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input int imm);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], 5'd0, 5'd0, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'($urandom_range(2, 31));
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        int sel;
        int imm;
        sel = $urandom_range(0, 9);
        imm = ($urandom_range(0, 255) - 128) * 4;
        if (sel <= 2)      return NOP;
        else if (sel == 3) return enc_jal(pick_reg(), imm);
        else if (sel <= 5) return enc_br(imm);
        else if (sel <= 7) return enc_jalr(pick_reg(), pick_reg());
        else if (sel == 8) return enc_jal(5'd1, imm);
        else               return $urandom;
    endfunction

    // ---------------- instruction memory (1-cycle BRAM model) ----------------
    logic [31:0] imem [logic [31:0]];
    bit          rand_mode;
    logic [31:0] last_pc;
    logic [31:0] last_pc_nb;

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if (!imem.exists(a)) begin
            if (!rand_mode) return NOP;
            imem[a] = rand_inst();
        end
        return imem[a];
    endfunction

    always @(negedge clk) begin
        last_pc    = pc;
        last_pc_nb = pc_nb;
    end

    always @(posedge clk) begin
        #1;
        inst    = fetch_word(last_pc);
        inst_nb = (last_pc_nb == 32'h20) ? enc_br(-8) : NOP;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_known;
    bit          m_run;
    bit          m_vld;
    logic [31:0] m_fpc;
    logic [31:0] ras_q[$];

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    always @(negedge clk) begin : model
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        int          jimm;
        int          bimm;
        bit          e_valid;
        bit          e_taken;
        logic [31:0] e_tgt;
        logic [31:0] e_pc;
        op   = inst[6:0];
        rd   = inst[11:7];
        rs1  = inst[19:15];
        jimm = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
               - (inst[31] ? 1048576 : 0);
        bimm = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048
               - (inst[31] ? 4096 : 0);
        e_valid = m_vld && !redirect_valid && m_run;
        e_taken = 1'b0;
        e_tgt   = m_fpc + 32'd4;
        if (m_vld) begin
            if (op == 7'h6F) begin
                e_taken = 1'b1;
                e_tgt   = m_fpc + $unsigned(jimm);
            end else if (op == 7'h63 && inst[31]) begin
                e_taken = 1'b1;
                e_tgt   = m_fpc + $unsigned(bimm);
            end else if (op == 7'h67 && rd == 5'd0 && is_link(rs1) && ras_q.size() > 0) begin
                e_taken = 1'b1;
                e_tgt   = ras_q[$];
            end
        end
        if (redirect_valid)         e_pc = {redirect_pc[31:2], 2'b00};
        else if (!m_run)            e_pc = 32'h0;
        else if (stall && m_vld)    e_pc = m_fpc;
        else                        e_pc = e_tgt;

        if (m_known) begin
            check("m_pc", pc, e_pc);
            check("m_id_valid", id_valid, e_valid);
            check("m_id_pc", id_pc, m_fpc);
            check("m_taken", id_pred_taken, e_taken);
            check("m_target", id_pred_target, e_tgt);
            check("m_dbg_run", dbg_run, m_run);
        end

        if (!rst_n) begin
            m_known = 1'b1;
            m_run   = 1'b0;
            m_vld   = 1'b0;
            m_fpc   = 32'h0;
            ras_q.delete();
        end else if (m_known) begin
            if (e_valid && !stall) begin
                if (op == 7'h67 && is_link(rd) && is_link(rs1) && rd != rs1) begin
                    if (ras_q.size() > 0) begin
                        void'(ras_q.pop_back());
                        ras_q.push_back(m_fpc + 32'd4);
                    end
                end else if ((op == 7'h6F || op == 7'h67) && is_link(rd)) begin
                    ras_q.push_back(m_fpc + 32'd4);
                    if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
                end else if (op == 7'h67 && rd == 5'd0 && is_link(rs1) && ras_q.size() > 0) begin
                    void'(ras_q.pop_back());
                end
            end
            if (!(m_run && m_vld && stall && !redirect_valid)) begin
                m_fpc = e_pc;
                m_vld = 1'b1;
            end
            m_run = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem.delete();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Returns at the negedge where id_pc==a is presented valid
    task automatic wait_id(input logic [31:0] a, input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (id_valid && id_pc == a) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        check({"wait_", tag}, ok, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] exp_q[$];
    logic [31:0] ret_at [4];

    initial begin
        n_checks = 0; n_fail = 0; rand_mode = 1'b0;
        m_known = 1'b0; m_run = 1'b0; m_vld = 1'b0; m_fpc = 32'h0;
        last_pc = 32'h0; last_pc_nb = 32'h0; inst = NOP; inst_nb = NOP;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // reset values and sequential fetch
        repeat (3) cyc();
        @(negedge clk);
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_taken", id_pred_taken, 1'b0);
        check("rst_target", id_pred_target, 32'h4);
        check("rst_pc", pc, 32'h0);
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        check("boot_pc", pc, 32'h0);
        check("boot_valid", id_valid, 1'b0);
        cyc(); @(negedge clk);
        check("first_valid", id_valid, 1'b1);
        check("first_id_pc", id_pc, 32'h0);
        check("seq_pc4", pc, 32'h4);
        cyc(); @(negedge clk);
        check("seq_pc8", pc, 32'h8);
        check("seq_id_pc4", id_pc, 32'h4);

        // JAL +0x100 at 0x10, no bubble
        do_reset();
        imem[32'h10] = enc_jal(5'd0, 32'h100);
        wait_id(32'h10, "jal");
        check("jal_pc", pc, 32'h110);
        check("jal_taken", id_pred_taken, 1'b1);
        check("jal_target", id_pred_target, 32'h110);
        cyc(); @(negedge clk);
        check("jal_next_valid", id_valid, 1'b1);
        check("jal_next_id_pc", id_pc, 32'h110);

        // backward branch taken; BTFN-disabled instance falls through
        do_reset();
        imem[32'h20] = enc_br(-8);
        wait_id(32'h20, "bwd");
        check("bwd_pc", pc, 32'h18);
        check("bwd_taken", id_pred_taken, 1'b1);
        check("nb_valid", valid_nb, 1'b1);
        check("nb_id_pc", id_pc_nb, 32'h20);
        check("nb_pc", pc_nb, 32'h24);
        check("nb_taken", taken_nb, 1'b0);

        // forward branch not taken
        do_reset();
        imem[32'h20] = enc_br(8);
        wait_id(32'h20, "fwd");
        check("fwd_pc", pc, 32'h24);
        check("fwd_taken", id_pred_taken, 1'b0);
        check("fwd_target", id_pred_target, 32'h24);

        // three stalled cycles at 0x40
        do_reset();
        wait_id(32'h3C, "pre_stall");
        cyc(); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'h40);
            check("stall_id_pc", id_pc, 32'h40);
            check("stall_valid", id_valid, 1'b1);
            check("stall_target", id_pred_target, 32'h44);
            cyc();
        end
        stall = 1'b0;
        @(negedge clk);
        check("release_pc", pc, 32'h44);
        check("release_id_pc", id_pc, 32'h40);
        cyc(); @(negedge clk);
        check("after_id_pc", id_pc, 32'h44);

        // call / return
        do_reset();
        imem[32'h80]  = enc_jal(5'd1, 32'h180);
        imem[32'h200] = enc_jalr(5'd0, 5'd1);
        wait_id(32'h80, "call");
        check("call_pc", pc, 32'h200);
        cyc();
        wait_id(32'h200, "ret");
        check("ret_pc", pc, 32'h84);
        check("ret_taken", id_pred_taken, 1'b1);

        // five nested calls with a 4-deep stack, then five returns
        do_reset();
        imem[32'h100]  = enc_jal(5'd1, 32'hF00);
        imem[32'h1000] = enc_jal(5'd1, 32'h1000);
        imem[32'h2000] = enc_jal(5'd1, 32'h1000);
        imem[32'h3000] = enc_jal(5'd1, 32'h1000);
        imem[32'h4000] = enc_jal(5'd1, 32'h1000);
        imem[32'h5000] = enc_jalr(5'd0, 5'd1);
        imem[32'h4004] = enc_jalr(5'd0, 5'd1);
        imem[32'h3004] = enc_jalr(5'd0, 5'd1);
        imem[32'h2004] = enc_jalr(5'd0, 5'd1);
        imem[32'h1004] = enc_jalr(5'd0, 5'd1);
        ret_at[0] = 32'h5000; ret_at[1] = 32'h4004; ret_at[2] = 32'h3004; ret_at[3] = 32'h2004;
        exp_q.push_back(32'h4004); exp_q.push_back(32'h3004);
        exp_q.push_back(32'h2004); exp_q.push_back(32'h1004);
        for (int k = 0; k < 4; k++) begin
            wait_id(ret_at[k], "nested_ret");
            check("ras_hit_pc", pc, exp_q.pop_front());
            check("ras_hit_taken", id_pred_taken, 1'b1);
            cyc();
        end
        wait_id(32'h1004, "ras_empty");
        check("ras_empty_pc", pc, 32'h1008);
        check("ras_empty_taken", id_pred_taken, 1'b0);

        // redirect wins over stall; low target bits dropped
        do_reset();
        wait_id(32'h8, "pre_redirect");
        cyc();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h303;
        @(negedge clk);
        check("redir_pc", pc, 32'h300);
        check("redir_valid", id_valid, 1'b0);
        cyc();
        stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_id_pc", id_pc, 32'h300);
        check("redir_id_valid", id_valid, 1'b1);
        check("redir_next_pc", pc, 32'h304);

        // randomized run against the model
        rand_mode = 1'b1;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'($urandom_range(0, 4095));
            rst_n          = ($urandom_range(0, 299) != 0);
            cyc();
        end
        stall = 1'b0; redirect_valid = 1'b0; rst_n = 1'b1;
        cyc();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
